// File: rtl/tilt_paddle_ctrl_if.sv
// ---------------------------------------------------------------------------
// tilt_paddle_ctrl_if : tilt code in, paddle position/status out   (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

interface tilt_paddle_ctrl_if #(
  parameter int XW = 10
);
  logic [7:0]    tilt_code;
  logic          enable;
  logic [XW-1:0] pos_x;
  logic [1:0]    dir;
  logic          moving;
  logic          move_pulse;
  logic          at_left;
  logic          at_right;

  modport master (
    output tilt_code, enable,
    input  pos_x, dir, moving, move_pulse, at_left, at_right
  );

  modport slave (
    input  tilt_code, enable,
    output pos_x, dir, moving, move_pulse, at_left, at_right
  );
endinterface

`default_nettype wire

// File: rtl/tilt_paddle_ctrl.sv
// ---------------------------------------------------------------------------
// tilt_paddle_ctrl : sync + debounce tilt code, HOLD/RIGHT/LEFT FSM, clamped X
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tilt_paddle_ctrl #(
  parameter int TICK_DIV     = 250000,
  parameter int STABLE_TICKS = 4,
  parameter int FAST_AFTER   = 32,
  parameter int STEP_SLOW    = 1,
  parameter int STEP_FAST    = 4,
  parameter int XW           = 10,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 600,
  parameter int X_INIT       = 300
) (
  input  wire logic        CLOCK_50,
  input  wire logic        rst_n,
  tilt_paddle_ctrl_if.slave bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW    = $clog2(STABLE_TICKS + 1);
  localparam int RW    = $clog2(FAST_AFTER + 1);

  localparam logic [CNT_W-1:0] c_tick_last = CNT_W'(TICK_DIV - 1);
  localparam logic [SW-1:0]    c_stable    = SW'(STABLE_TICKS);
  localparam logic [RW-1:0]    c_fast      = RW'(FAST_AFTER);
  localparam logic [XW:0]      c_xmin      = (XW+1)'(X_MIN);
  localparam logic [XW:0]      c_xmax      = (XW+1)'(X_MAX);
  localparam logic [XW:0]      c_step_slow = (XW+1)'(STEP_SLOW);
  localparam logic [XW:0]      c_step_fast = (XW+1)'(STEP_FAST);

  typedef enum logic [1:0] {
    S_HOLD  = 2'b00,
    S_RIGHT = 2'b01,
    S_LEFT  = 2'b10
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_sync1, r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_cand, r_acc;
  logic [SW-1:0]    r_stable;
  logic [RW-1:0]    r_run;
  logic [XW-1:0]    r_pos;
  logic             r_move_pulse;

  logic             w_tick;
  logic [1:0]       w_sample, w_cand_nxt;
  logic [SW-1:0]    w_stable_nxt;
  logic             w_move;
  logic [XW:0]      w_step, w_pos_ext, w_sum;
  logic [XW-1:0]    w_pos_nxt;
  logic             w_unused_hi;

  assign w_unused_hi = ^bus.tilt_code[7:2];

  // tilt_code comes from a slower derived clock; only the two direction bits cross
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= bus.tilt_code[1:0];
      r_sync2 <= r_sync1;
      r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
    end
  end

  assign w_tick       = (r_cnt == c_tick_last);
  assign w_sample     = (r_sync2 == 2'b11) ? 2'b00 : r_sync2;
  assign w_cand_nxt   = w_sample;
  assign w_stable_nxt = (w_sample != r_cand)  ? SW'(1) :
                        (r_stable == c_stable) ? r_stable : r_stable + 1'b1;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_HOLD;
    end else if (w_tick) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_move      = 1'b0;
    unique case (r_state)
      S_HOLD: begin
        if (bus.enable && r_acc == 2'b01)      w_state_nxt = S_RIGHT;
        else if (bus.enable && r_acc == 2'b10) w_state_nxt = S_LEFT;
      end
      S_RIGHT: begin
        if (!bus.enable || r_acc != 2'b01) w_state_nxt = S_HOLD;
        else                               w_move      = 1'b1;
      end
      S_LEFT: begin
        if (!bus.enable || r_acc != 2'b10) w_state_nxt = S_HOLD;
        else                               w_move      = 1'b1;
      end
      default: w_state_nxt = S_HOLD;
    endcase
  end

  // one extra bit keeps both the overflow and underflow comparisons honest
  assign w_step    = (r_run == c_fast) ? c_step_fast : c_step_slow;
  assign w_pos_ext = {1'b0, r_pos};
  assign w_sum     = w_pos_ext + w_step;

  always_comb begin
    w_pos_nxt = r_pos;
    if (w_move) begin
      if (r_state == S_RIGHT)
        w_pos_nxt = (w_sum > c_xmax) ? c_xmax[XW-1:0] : w_sum[XW-1:0];
      else
        w_pos_nxt = (w_pos_ext < c_xmin + w_step) ? c_xmin[XW-1:0]
                                                  : r_pos - w_step[XW-1:0];
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_cand       <= 2'b00;
      r_stable     <= '0;
      r_acc        <= 2'b00;
      r_run        <= '0;
      r_pos        <= XW'(X_INIT);
      r_move_pulse <= 1'b0;
    end else if (w_tick) begin
      r_cand       <= w_cand_nxt;
      r_stable     <= w_stable_nxt;
      if (w_stable_nxt == c_stable) r_acc <= w_cand_nxt;
      r_pos        <= w_pos_nxt;
      r_move_pulse <= (w_pos_nxt != r_pos);
      if (w_state_nxt == S_HOLD)        r_run <= '0;
      else if (w_move && r_run != c_fast) r_run <= r_run + 1'b1;
    end else begin
      r_move_pulse <= 1'b0;
    end
  end

  assign bus.pos_x      = r_pos;
  assign bus.dir        = r_state;
  assign bus.moving     = (r_state != S_HOLD);
  assign bus.move_pulse = r_move_pulse;
  assign bus.at_left    = (r_pos == c_xmin[XW-1:0]);
  assign bus.at_right   = (r_pos == c_xmax[XW-1:0]);

endmodule

`default_nettype wire

// File: tb/tb_tilt_paddle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tilt_paddle_ctrl : random tilt stimulus vs. per-tick behavioural model
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tilt_paddle_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       rst_n;
  logic [7:0] tilt;
  logic       en;

  always #10 CLOCK_50 = ~CLOCK_50;

  tilt_paddle_ctrl_if #(.XW(10)) bus0 ();
  tilt_paddle_ctrl_if #(.XW(10)) bus1 ();

  assign bus0.tilt_code = tilt;
  assign bus0.enable    = en;
  assign bus1.tilt_code = tilt;
  assign bus1.enable    = en;

  tilt_paddle_ctrl #(.TICK_DIV(10)) dut0 (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .bus      (bus0.slave)
  );

  tilt_paddle_ctrl #(.TICK_DIV(10), .X_MAX(335)) dut1 (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .bus      (bus1.slave)
  );

  int n_total = 0;
  int n_bad   = 0;
  int pend    = 10;
  int cur_code;
  int xmax [2] = '{600, 335};
  int m_pos [2];
  int m_st [2];
  int m_moves [2];
  int m_pulse [2];
  int m_acc;
  int hist [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_acc = 0;
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = 300; m_st[i] = 0; m_moves[i] = 0; m_pulse[i] = 0;
    end
  endtask

  // Direction: 0 hold, 1 right, 2 left. Accepted code = sample whenever the
  // last four tick samples agree; the FSM sees the value from before this tick.
  task automatic model_tick(input int code, input int e);
    int s, acc_old, tgt, nst, old, step;
    bit same;
    s = (code == 3) ? 0 : code;
    acc_old = m_acc;
    for (int i = 0; i < 2; i++) begin
      tgt = (e != 0 && acc_old == 1) ? 1 : (e != 0 && acc_old == 2) ? 2 : 0;
      nst = (m_st[i] == 0) ? tgt : ((m_st[i] == tgt) ? m_st[i] : 0);
      old = m_pos[i];
      if (m_st[i] != 0 && nst == m_st[i]) begin
        step = (m_moves[i] >= 32) ? 4 : 1;
        if (m_st[i] == 1) m_pos[i] = (old + step > xmax[i]) ? xmax[i] : old + step;
        else              m_pos[i] = (old - step < 0) ? 0 : old - step;
        m_moves[i]++;
      end else if (nst == 0) begin
        m_moves[i] = 0;
      end
      m_pulse[i] = (m_pos[i] != old) ? 1 : 0;
      m_st[i] = nst;
    end
    hist.push_back(s);
    if (hist.size() > 4) void'(hist.pop_front());
    if (hist.size() == 4) begin
      same = 1'b1;
      for (int k = 0; k < 4; k++) if (hist[k] != s) same = 1'b0;
      if (same) m_acc = s;
    end
  endtask

  task automatic chk_inst(input int i, input logic [9:0] pos, input logic [1:0] dir,
                          input logic mv, input logic pulse, input logic al, input logic ar);
    string p;
    p = (i == 0) ? "u0" : "u1";
    chk({p, ".pos_x"},      32'(pos),   32'(m_pos[i]));
    chk({p, ".dir"},        32'(dir),   32'(m_st[i]));
    chk({p, ".moving"},     32'(mv),    32'(m_st[i] != 0));
    chk({p, ".move_pulse"}, 32'(pulse), 32'(m_pulse[i]));
    chk({p, ".at_left"},    32'(al),    32'(m_pos[i] == 0));
    chk({p, ".at_right"},   32'(ar),    32'(m_pos[i] == xmax[i]));
  endtask

  task automatic set_in(input int code, input int e);
    tilt     = {6'($urandom), 2'(code)};
    en       = (e != 0);
    cur_code = code;
  endtask

  task automatic do_tick();
    repeat (pend) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    model_tick(cur_code, int'(en));
    chk_inst(0, bus0.pos_x, bus0.dir, bus0.moving, bus0.move_pulse, bus0.at_left, bus0.at_right);
    chk_inst(1, bus1.pos_x, bus1.dir, bus1.moving, bus1.move_pulse, bus1.at_left, bus1.at_right);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("u0.pulse_width", 32'(bus0.move_pulse), 32'd0);
    chk("u1.pulse_width", 32'(bus1.move_pulse), 32'd0);
    pend = 9;
  endtask

  task automatic run(input int code, input int e, input int n);
    set_in(code, e);
    for (int k = 0; k < n; k++) do_tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".u0.pos_x"}, 32'(bus0.pos_x), 32'd300);
    chk({tag, ".u0.dir"},   32'(bus0.dir),   32'd0);
    chk({tag, ".u0.moving"},32'(bus0.moving),32'd0);
    chk({tag, ".u0.pulse"}, 32'(bus0.move_pulse), 32'd0);
    chk({tag, ".u0.at_l"},  32'(bus0.at_left),  32'd0);
    chk({tag, ".u0.at_r"},  32'(bus0.at_right), 32'd0);
    chk({tag, ".u1.pos_x"}, 32'(bus1.pos_x), 32'd300);
    chk({tag, ".u1.dir"},   32'(bus1.dir),   32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0);
    repeat (3) @(negedge CLOCK_50);
    rst_n = 1'b1;
    #1;
    chk_reset_vals("reset");
    model_reset();
    pend = 10;
    @(negedge CLOCK_50);
    pend = 9;

    // short glitch and the illegal 2'b11 code must never move the paddle
    run(1, 1, 3);
    run(0, 1, 6);
    run(3, 1, 8);
    chk("glitch.dir", 32'(bus0.dir), 32'd0);
    chk("glitch.pos", 32'(bus0.pos_x), 32'd300);

    // right tilt: accepted tick 4, dir tick 5, first move tick 6
    set_in(1, 1);
    for (int t = 1; t <= 45; t++) begin
      do_tick();
      if (t == 5)  chk("lat.dir_tick5", 32'(bus0.dir), 32'd1);
      if (t == 6)  chk("lat.pos_tick6", 32'(bus0.pos_x), 32'd301);
      if (t == 37) chk("slow.pos_32", 32'(bus0.pos_x), 32'd332);
      if (t == 38) chk("fast.pos_33", 32'(bus0.pos_x), 32'd336);
      if (t == 38) chk("clamp.pos", 32'(bus1.pos_x), 32'd335);
      if (t == 40) chk("clamp.pulse", 32'(bus1.move_pulse), 32'd0);
    end

    // reversal down to the left bound
    run(2, 1, 150);
    chk("left.bound", 32'(bus0.at_left), 32'd1);

    for (int seg = 0; seg < 40; seg++)
      run(int'($urandom_range(0, 3)), ($urandom_range(0, 7) != 0) ? 1 : 0,
          int'($urandom_range(1, 10)));

    run(1, 1, 12);
    run(1, 0, 3);
    chk("enable.dir", 32'(bus0.dir), 32'd0);
    run(1, 1, 10);

    // asynchronous reset taken between clock edges
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    model_reset();
    rst_n = 1'b1;
    pend = 10;
    run(2, 1, 10);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
